// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS54 execution-stage arithmetic units.
package cpu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/divu_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// subtract the divisor when it fits, and shift the quotient bit in.
module divu_step
  import cpu_pkg::*;
(
  input  logic [WIDTH-1:0] wr,
  input  logic [WIDTH-1:0] wq,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] wr_next,
  output logic [WIDTH-1:0] wq_next
);

  logic [WIDTH:0] trial;

  // wr < d always holds, so a negative trial leaves a shifted remainder that still fits
  always_comb begin
    trial = {wr, wq[WIDTH-1]} - {1'b0, d};
    if (!trial[WIDTH]) begin
      wr_next = trial[WIDTH-1:0];
      wq_next = {wq[WIDTH-2:0], 1'b1};
    end else begin
      wr_next = {wr[WIDTH-2:0], wq[WIDTH-1]};
      wq_next = {wq[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divu.sv
// Multi-cycle unsigned divider (DIVU): quotient to LO (q), remainder to HI (r),
// one quotient bit per clock behind a start/busy/done handshake.
module divu
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  div_state_e       state, state_nxt;
  logic [WIDTH-1:0] wq, wq_nxt;
  logic [WIDTH-1:0] wr, wr_nxt;
  logic [WIDTH-1:0] d, d_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] q_nxt, r_nxt;
  logic             busy_nxt, done_nxt, div_zero_nxt;
  logic [WIDTH-1:0] wr_step, wq_step;

  divu_step u_step (
    .wr      (wr),
    .wq      (wq),
    .d       (d),
    .wr_next (wr_step),
    .wq_next (wq_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wq       <= '0;
      wr       <= '0;
      d        <= '0;
      cnt      <= '0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      wq       <= wq_nxt;
      wr       <= wr_nxt;
      d        <= d_nxt;
      cnt      <= cnt_nxt;
      q        <= q_nxt;
      r        <= r_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  // Result registers only move on the completion edge; start during RUN is dropped
  always_comb begin
    state_nxt    = state;
    wq_nxt       = wq;
    wr_nxt       = wr;
    d_nxt        = d;
    cnt_nxt      = cnt;
    q_nxt        = q;
    r_nxt        = r;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    div_zero_nxt = div_zero;

    case (state)
      IDLE: begin
        if (start) begin
          wq_nxt       = a;
          wr_nxt       = '0;
          d_nxt        = b;
          cnt_nxt      = '0;
          div_zero_nxt = (b == '0);
          busy_nxt     = 1'b1;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        wq_nxt  = wq_step;
        wr_nxt  = wr_step;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          q_nxt     = wq_step;
          r_nxt     = wr_step;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_divu.sv
// Scoreboard bench for divu: a cycle-level timing model pushes expected results
// at each accept, a negedge monitor pops them on done and checks every output.
module tb_divu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        div_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t        sb[$];
  int          m_left;
  logic        m_done;
  logic        m_dz;
  logic [31:0] hold_q;
  logic [31:0] hold_r;
  int          checks;
  int          errors;

  divu dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_div(input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    if (bv == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = av;
    end else begin
      e.q = av / bv;
      e.r = av % bv;
    end
    return e;
  endfunction

  // Timing model: accept when idle, 32 busy cycles, then one done cycle
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      sb.delete();
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_done <= 1'b1;
      end else if (start) begin
        m_left <= 32;
        m_dz   <= (b == 32'd0);
        sb.push_back(ref_div(a, b));
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_q", q, 32'd0);
      chk("rst_r", r, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
      hold_q = 32'd0;
      hold_r = 32'd0;
    end else begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("div_zero", 32'(div_zero), 32'(m_dz));
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("q", q, e.q);
          chk("r", r, e.r);
          hold_q = e.q;
          hold_r = e.r;
        end
      end else begin
        chk("q_hold", q, hold_q);
        chk("r_hold", r, hold_r);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv);
    int n;
    n = 0;
    while (m_left != 0 && n < 100) begin
      step();
      n++;
    end
    start = 1'b1;
    a     = av;
    b     = bv;
    step();
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    hold_q = 32'd0;
    hold_r = 32'd0;
    reset  = 1'b1;
    start  = 1'b0;
    a      = 32'd0;
    b      = 32'd0;
    step();
    step();
    reset = 1'b0;
    step();

    do_op(32'd100, 32'd7);
    do_op(32'hFFFF_FFFF, 32'd1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(32'd5, 32'd0);
    do_op(32'd3, 32'd10);
    step();

    // start during RUN is ignored; start held into the done cycle is accepted
    start = 1'b1; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0;
    repeat (9) step();
    start = 1'b1; a = 32'd9; b = 32'd3;
    step();
    start = 1'b0;
    n = 0;
    while (m_left != 1 && n < 40) begin
      step();
      n++;
    end
    start = 1'b1; a = 32'd9; b = 32'd3;
    step();
    step();
    start = 1'b0;
    wait_done();
    step();

    // reset mid-RUN, with start held across reset release
    start = 1'b1; a = 32'd1000; b = 32'd3;
    step();
    start = 1'b0;
    repeat (15) step();
    reset = 1'b1;
    start = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    start = 1'b0;
    wait_done();

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom % 4)
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = ra >> ($urandom % 32);
        default: rb = ($urandom % 3 == 0) ? 32'd0 : ($urandom & 32'h0000_FFFF);
      endcase
      do_op(ra, rb);
    end

    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divu.md
# divu

Multi-cycle unsigned 32-bit divider for the MIPS54 CPU execution stage, the inverse counterpart to the combinational unsigned multiplier.
- Computes quotient (written to LO) and remainder (written to HI) for DIVU using a radix-2 restoring algorithm, one quotient bit per clock.
- A start/busy/done handshake lets the pipeline stall while the divider runs.

## Interface
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only on a clk edge where busy=0.
- a  in  WIDTH  dividend; sampled at accept.
- b  in  WIDTH  divisor; sampled at accept.
- q  out  WIDTH  quotient (to LO).
- r  out  WIDTH  remainder (to HI).
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; q/r/div_zero are valid from this cycle.
- div_zero  out  1  high when the last accepted divisor was 0.

## Operation
- States: IDLE, RUN. Reset forces IDLE.
- Reset values: q=0, r=0, busy=0, done=0, div_zero=0, iteration counter=0.
- IDLE with start=1 (accept edge):
  - Load working quotient register wq←a.
  - Load working remainder wr←0 and divisor register d←b.
  - Counter←0; div_zero←(b==0).
  - Go to RUN.
- RUN, each edge:
  - trial = {wr, wq[WIDTH-1]} − {1'b0, d}, computed at WIDTH+1 bits.
  - If trial MSB=0: wr←trial[WIDTH-1:0] and wq←{wq[WIDTH-2:0],1}.
  - Else: wr←{wr[WIDTH-2:0],wq[WIDTH-1]} and wq←{wq[WIDTH-2:0],0}.
  - Counter increments on each of these edges.
- On the WIDTH-th RUN edge:
  - Copy q←final wq and r←final wr; pulse done=1 for one cycle.
  - Go to IDLE.
- q and r are result registers. They hold the previous result for the whole of RUN and change only on the completion edge.
- Divide by zero needs no special path. The algorithm yields q=all ones and r=a, and div_zero=1 flags it.
- start while busy=1 is ignored; nothing is queued.
- start is level-sampled. If start is held high in IDLE, a new operation is accepted on every idle edge, including the cycle done=1.
- Arithmetic is purely unsigned, with no overflow case. Signed DIV is out of scope and is handled by a wrapper.

## Timing
- Accept edge E0: busy=1 from E0 onward.
- Iteration edges E1..E32.
- After E32: busy=0, done=1, and q/r/div_zero hold the new values.
- Latency is 33 edges from accept to result visible, so busy is high for exactly 32 cycles.
- Back-to-back: start=1 in the done cycle is accepted at the next edge. Throughput is one division per 33 cycles.
- done is registered and deasserts on the next edge.
- reset asserted mid-RUN:
  - Immediately clears all outputs and returns the block to IDLE.
  - No done pulse is produced.
  - A start held high across reset release is accepted on the first edge after release.
- div_zero updates on the accept edge and holds until the next accept.

## Structure
- Shared package (cpu_pkg) holds:
  - The WIDTH constant (32).
  - The divider state enum {IDLE, RUN}.
  - The counter width, $clog2(WIDTH)+1.
- Sub-module divu_step: a combinational single iteration.
  - Inputs: wr, wq, d. Outputs: next wr, next wq.
  - Instantiated once in divu; the sequential control, counter and result registers live in divu.

## Test plan
- a=100, b=7, start pulse → busy high 32 cycles, then done with q=14, r=2, div_zero=0.
- a=0xFFFFFFFF, b=1 → q=0xFFFFFFFF, r=0. Then a=0xFFFFFFFF, b=0xFFFFFFFF → q=1, r=0.
- a=5, b=0 → q=0xFFFFFFFF, r=5, div_zero=1.
- a=3, b=10 → q=0, r=3.
- Start a=100, b=7. Pulse start with a=9, b=3 at cycle 10 of RUN → ignored, result still q=14, r=2. start=1 in the done cycle with a=9, b=3 → accepted, q=3, r=0 33 edges later.
- Start a=1000, b=3, assert reset at cycle 15 → busy=0, q=r=0, no done. After release, a=1000, b=3 → q=333, r=1.
